// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: result word width and the destination
// select encoding used by both the 2:1 result mux and the 1:2 result demux.
package alu_pkg;

    localparam int   ALU_WIDTH = 32;

    // Select encoding: 0 steers to destination A, 1 to destination B.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : alu_pkg

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding ALU result words for one destination.
// Occupancy is kept in an explicit count register; full and empty are
// derived from it, so the pointers only need log2(DEPTH) bits.
module result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if it pops in the same cycle, and a pop
    // while empty is ignored.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage: write the pushed word at the write pointer.
    // NOTE: storage is reset so the head output reads 0 after reset rather
    // than X; affordable at this depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net push minus pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule : result_fifo

// File: rtl/alu_result_demux.sv
// Buffered 1-to-2 demultiplexer for ALU results. Each accepted word goes to
// the A or B FIFO by its select bit, so a stalled consumer on one side does
// not block traffic to the other.
module alu_result_demux
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [WIDTH-1:0]         a_data,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [WIDTH-1:0]         b_data,
    output logic [$clog2(DEPTH):0]   b_count
);

    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic push_a;
    logic push_b;

    // Steering: in_ready depends only on in_sel and registered FIFO state,
    // never on a_ready/b_ready.
    // NOTE: every signal driven here gets a default first so no latch can be
    // inferred on any path.
    always_comb begin
        in_ready = 1'b0;
        push_a   = 1'b0;
        push_b   = 1'b0;
        if (in_sel == SEL_A) begin
            in_ready = ~a_full;
            push_a   = in_valid & ~a_full;
        end else begin
            in_ready = ~b_full;
            push_b   = in_valid & ~b_full;
        end
    end

    assign a_valid = ~a_empty;
    assign b_valid = ~b_empty;

    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head      (a_data),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head      (b_data),
        .full      (b_full),
        .empty     (b_empty),
        .count     (b_count)
    );

endmodule : alu_result_demux

// File: tb/tb_alu_result_demux.sv
// Directed self-checking bench for alu_result_demux (WIDTH=32, DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs are checked
// there too, well away from the next edge.
module tb_alu_result_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [1:0]  a_count;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_demux #(.WIDTH(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset held with in_valid=1: nothing may be accepted.
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_a_valid",  32'(a_valid),  32'd0);
        check("rst_b_valid",  32'(b_valid),  32'd0);
        check("rst_a_count",  32'(a_count),  32'd0);
        check("rst_b_count",  32'(b_count),  32'd0);
        check("rst_a_data",   a_data,        32'd0);
        check("rst_b_data",   b_data,        32'd0);

        // Release between edges; the next edge accepts DEADBEEF into A.
        rst_n = 1'b1;
        step();
        check("first_a_valid", 32'(a_valid), 32'd1);
        check("first_a_data",  a_data,       32'hDEAD_BEEF);
        check("first_b_valid", 32'(b_valid), 32'd0);
        check("first_a_count", 32'(a_count), 32'd1);

        // Drain it.
        in_valid = 1'b0;
        a_ready  = 1'b1;
        step();
        a_ready  = 1'b0;
        check("drain_a_count", 32'(a_count), 32'd0);
        check("drain_a_valid", 32'(a_valid), 32'd0);

        // Fill A with 1, 2 while a_ready=0.
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h1;
        step();
        in_data  = 32'h2;
        step();
        check("fill_a_count", 32'(a_count), 32'd2);
        check("fill_a_head",  a_data,       32'h1);
        check("fill_ready_a", 32'(in_ready), 32'd0);
        in_sel  = 1'b1;
        in_data = 32'h3;
        #1;
        check("fill_ready_b", 32'(in_ready), 32'd1);
        step();
        check("fill_b_count", 32'(b_count), 32'd1);
        check("fill_b_data",  b_data,       32'h3);
        check("fill_a_keep",  32'(a_count), 32'd2);

        // Full A with a pop in the same cycle: the push is refused.
        in_sel   = 1'b0;
        in_data  = 32'h4;
        a_ready  = 1'b1;
        b_ready  = 1'b0;
        #1;
        check("full_pop_ready", 32'(in_ready), 32'd0);
        step();
        check("full_pop_count", 32'(a_count), 32'd1);
        check("full_pop_head",  a_data,       32'h2);
        check("full_pop_ready2", 32'(in_ready), 32'd1);
        a_ready = 1'b0;
        step();
        check("retry_a_count", 32'(a_count), 32'd2);
        check("retry_a_head",  a_data,       32'h2);
        in_valid = 1'b0;

        // Asynchronous reset between edges with a_count=2, b_count=1.
        check("pre_rst_b_count", 32'(b_count), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_count", 32'(a_count), 32'd0);
        check("mid_rst_b_count", 32'(b_count), 32'd0);
        check("mid_rst_a_valid", 32'(a_valid), 32'd0);
        check("mid_rst_b_valid", 32'(b_valid), 32'd0);
        check("mid_rst_a_data",  a_data,       32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_a_valid", 32'(a_valid), 32'd0);
        check("post_rst_b_valid", 32'(b_valid), 32'd0);
        check("post_rst_b_data",  b_data,       32'd0);

        // Streaming: words 0..7, alternating select, both consumers ready.
        // Each word is visible on its side right after its accept edge and
        // leaves at the following edge, so occupancy stays at 1.
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = i[0];
            in_data  = 32'(i);
            #1;
            check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
            step();
            if (i[0]) begin
                check($sformatf("stream_b_data_%0d", i),  b_data,        32'(i));
                check($sformatf("stream_b_count_%0d", i), 32'(b_count),  32'd1);
                check($sformatf("stream_a_valid_%0d", i), 32'(a_valid),  32'd0);
            end else begin
                check($sformatf("stream_a_data_%0d", i),  a_data,        32'(i));
                check($sformatf("stream_a_count_%0d", i), 32'(a_count),  32'd1);
                if (i > 0) check($sformatf("stream_b_valid_%0d", i), 32'(b_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        step();
        check("stream_end_a_valid", 32'(a_valid), 32'd0);
        check("stream_end_b_valid", 32'(b_valid), 32'd0);

        // Wrap-around through B: fill to 2, then drain while refilling so
        // both pointers cross the wrap several times.
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h100;
        step();
        in_data  = 32'h101;
        step();
        check("wrap_full_count", 32'(b_count), 32'd2);
        check("wrap_head0",      b_data,       32'h100);
        // Full: pop only, push refused.
        b_ready = 1'b1;
        in_data = 32'h102;
        step();
        check("wrap_head1",  b_data,       32'h101);
        check("wrap_count1", 32'(b_count), 32'd1);
        // Non-full: push and pop together, count unchanged.
        step();
        check("wrap_head2",  b_data,       32'h102);
        check("wrap_count2", 32'(b_count), 32'd1);
        in_data = 32'h103;
        step();
        check("wrap_head3",  b_data,       32'h103);
        check("wrap_count3", 32'(b_count), 32'd1);
        in_data = 32'h104;
        step();
        check("wrap_head4",  b_data,       32'h104);
        check("wrap_count4", 32'(b_count), 32'd1);
        in_valid = 1'b0;
        step();
        check("wrap_empty_count", 32'(b_count), 32'd0);
        check("wrap_empty_valid", 32'(b_valid), 32'd0);
        check("wrap_a_untouched", 32'(a_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_result_demux

// File: doc/alu_result_demux.md
# alu_result_demux

Buffered 1-to-2 demultiplexer for 32-bit ALU results: the write-side counterpart of the 2:1 result-select mux. It accepts one valid/ready stream, steers each accepted word to destination A or B according to a per-word select bit, and holds it in a small per-destination FIFO. Downstream stalls on one destination therefore do not block traffic to the other. It sits between the ALU output stage and the two consumers (register writeback and memory/store path).

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 2, entries per destination FIFO; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  input word present
- `in_ready`  out  1  input word accepted this cycle when high together with `in_valid`
- `in_data`  in  WIDTH  input word
- `in_sel`  in  1  destination: 0 → A, 1 → B (same polarity as the 2:1 mux)
- `a_valid` / `b_valid`  out  1  destination FIFO non-empty
- `a_ready` / `b_ready`  in  1  consumer takes the head word
- `a_data` / `b_data`  out  WIDTH  head word of each FIFO
- `a_count` / `b_count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Accept = `in_valid & in_ready`. On accept, `in_data` is pushed into FIFO A if `in_sel`=0, otherwise FIFO B. The other FIFO is untouched.
- `in_ready` = NOT full of the FIFO selected by the current `in_sel`.
  - Combinational from `in_sel` and registered state only.
  - No path from `a_ready`/`b_ready`: a full FIFO refuses a push even when it pops in the same cycle.
- Pop = `x_valid & x_ready` per destination. It advances the read pointer. `x_ready` while empty has no effect.
- A simultaneous push and pop on the same non-full FIFO leaves the count unchanged, with both pointers advancing.
- Push and pop on different FIFOs in the same cycle are fully independent.
- Each FIFO has pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Full/empty are taken from the count register: full = count==DEPTH, empty = count==0.
- Ordering: FIFO order is preserved within each destination. There is no ordering relation between A and B.
- `in_sel` and `in_data` are sampled only on accept. Their values while `in_valid`=0 are don't-care.
- Reset mid-operation discards all buffered words immediately. No partial state survives.

## Timing
- Reset values:
  - `in_ready` follows `in_sel` against empty FIFOs, so it is 1.
  - `a_valid`, `b_valid` = 0.
  - `a_count`, `b_count` = 0.
  - Pointers = 0. Storage cleared to 0, so `a_data`, `b_data` = 0.
- Latency: a word accepted at edge k appears on `x_data` with `x_valid`=1 immediately after edge k, provided its FIFO was empty.
- `x_data` is valid only while `x_valid`=1. It is stable while `x_valid`=1 and `x_ready`=0.
- Throughput: one accept per cycle sustained while the selected consumer keeps `x_ready` high. With DEPTH=2 this holds with no bubbles.
- Counts update at the same edge as the push/pop that changes them.

## Structure
- Shared package `alu_pkg`: `ALU_WIDTH`=32 and the select encoding constants `SEL_A`=0 and `SEL_B`=1. The 2:1 mux uses the same constants.
- One sub-module, `result_fifo`.
  - Parameterized WIDTH and DEPTH.
  - Ports: push/pop/data, full/empty/count.
  - Instantiated twice.
- The top level holds only the steering logic and the `in_ready` select.

## Test plan
- Reset with `in_valid`=1 held: all outputs match their reset values. Release `rst_n`, drive `in_data`=32'hDEADBEEF with `in_sel`=0 → `a_valid`=1 and `a_data`=32'hDEADBEEF the next cycle, `b_valid`=0.
- Fill A: hold `a_ready`=0 and push 32'h1 then 32'h2 to A → `a_count`=2. Drive `in_sel`=0 → `in_ready`=0. Switch `in_sel`=1 → `in_ready`=1 and 32'h3 lands in B.
- Full A with `a_ready`=1 and a push to A in the same cycle → push refused (`in_ready`=0). 32'h1 pops, `a_count`=1. Next cycle the push is accepted.
- Streaming: 8 words 0..7 with alternating `in_sel` and both readies high → A sees 0,2,4,6 and B sees 1,3,5,7, one accept per cycle.
- Wrap-around: push and pop 5 words through B with DEPTH=2 → data order is preserved across pointer wrap and `b_count` never exceeds 2.
- Reset mid-operation: with `a_count`=2 and `b_count`=1, assert `rst_n`=0 asynchronously between edges → counts 0 and valids 0 immediately. After release, no stale data appears.
